// File: rtl/draw_pkg.sv
// Shared types and constants for the draw command sequencer and its FIFO.
// Commands are packed so the FIFO can store them as one word.
package draw_pkg;

  localparam int VGA_W    = 160;
  localparam int VGA_H    = 120;
  localparam int COORD_XW = 8;
  localparam int COORD_YW = 7;

  typedef enum logic {
    OP_FILL   = 1'b0,
    OP_CIRCLE = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RELEASE
  } seq_state_t;

  typedef struct packed {
    op_t                 op;
    logic [2:0]          colour;
    logic [COORD_XW-1:0] cx;
    logic [COORD_YW-1:0] cy;
    logic [7:0]          r;
  } draw_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO of draw commands; head entry is read combinationally.
// Push is ignored when full and pop is ignored when empty.
module cmd_fifo
  import draw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  draw_cmd_t push_data,
  input  logic      pop,
  output draw_cmd_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  draw_cmd_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/draw_sequencer.sv
// Runs queued fill/circle commands one at a time on the two drawing engines
// and owns the VGA pixel port, forwarding only the active engine's writes.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32767
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [2:0]          cmd_colour,
  input  logic [COORD_XW-1:0] cmd_cx,
  input  logic [COORD_YW-1:0] cmd_cy,
  input  logic [7:0]          cmd_r,
  output logic                fill_rst_n,
  output logic                fill_start,
  output logic [2:0]          fill_colour,
  input  logic                fill_done,
  input  logic [COORD_XW-1:0] fill_x,
  input  logic [COORD_YW-1:0] fill_y,
  input  logic                fill_plot,
  input  logic [2:0]          fill_vcolour,
  output logic                circ_rst_n,
  output logic                circ_start,
  output logic [2:0]          circ_colour,
  output logic [COORD_XW-1:0] circ_cx,
  output logic [COORD_YW-1:0] circ_cy,
  output logic [7:0]          circ_r,
  input  logic                circ_done,
  input  logic [COORD_XW-1:0] circ_x,
  input  logic [COORD_YW-1:0] circ_y,
  input  logic                circ_plot,
  input  logic [2:0]          circ_vcolour,
  output logic [COORD_XW-1:0] vga_x,
  output logic [COORD_YW-1:0] vga_y,
  output logic [2:0]          vga_colour,
  output logic                vga_plot,
  output logic                idle,
  output logic                err,
  output logic [7:0]          done_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT - 1);

  seq_state_t    state;
  seq_state_t    state_next;
  op_t           sel_op;
  logic [TW-1:0] tcount;
  draw_cmd_t     cmd_in;
  draw_cmd_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          sel_done;
  logic          timeout_hit;

  assign cmd_in.op     = op_t'(cmd_op);
  assign cmd_in.colour = cmd_colour;
  assign cmd_in.cx     = cmd_cx;
  assign cmd_in.cy     = cmd_cy;
  assign cmd_in.r      = cmd_r;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready   = !fifo_full;
  assign idle        = fifo_empty && (state == S_IDLE);
  assign pop         = (state == S_IDLE) && !fifo_empty;
  assign sel_done    = (sel_op == OP_CIRCLE) ? circ_done : fill_done;
  // Done has priority over a timeout landing in the same cycle.
  assign timeout_hit = (state == S_RUN) && !sel_done && (tcount == T_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (!fifo_empty) state_next = S_LOAD;
      S_LOAD:    state_next = S_RUN;
      S_RUN:     if (sel_done || timeout_hit) state_next = S_RELEASE;
      S_RELEASE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcount     <= '0;
      err        <= 1'b0;
      done_count <= '0;
    end else begin
      if (state == S_LOAD)     tcount <= '0;
      else if (state == S_RUN) tcount <= tcount + 1'b1;
      if (timeout_hit) err <= 1'b1;
      if (state == S_RUN && sel_done) done_count <= done_count + 1'b1;
    end
  end

  // The idle engine's parameter registers are cleared so its inputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_op      <= OP_FILL;
      fill_colour <= '0;
      circ_colour <= '0;
      circ_cx     <= '0;
      circ_cy     <= '0;
      circ_r      <= '0;
    end else if (pop) begin
      sel_op <= head.op;
      if (head.op == OP_FILL) begin
        fill_colour <= head.colour;
        circ_colour <= '0;
        circ_cx     <= '0;
        circ_cy     <= '0;
        circ_r      <= '0;
      end else begin
        fill_colour <= '0;
        circ_colour <= head.colour;
        circ_cx     <= head.cx;
        circ_cy     <= head.cy;
        circ_r      <= head.r;
      end
    end
  end

  // Engines are out of reset and started only in RUN; the pixel port follows.
  always_comb begin
    fill_rst_n = 1'b0;
    fill_start = 1'b0;
    circ_rst_n = 1'b0;
    circ_start = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (state == S_RUN) begin
      if (sel_op == OP_CIRCLE) begin
        circ_rst_n = 1'b1;
        circ_start = 1'b1;
        vga_x      = circ_x;
        vga_y      = circ_y;
        vga_colour = circ_vcolour;
        vga_plot   = circ_plot;
      end else begin
        fill_rst_n = 1'b1;
        fill_start = 1'b1;
        vga_x      = fill_x;
        vga_y      = fill_y;
        vga_colour = fill_vcolour;
        vga_plot   = fill_plot;
      end
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: engine models plus a manual drive mode for
// table-driven pixel-mux vectors, then directed multi-cycle sequences.
module tb_draw_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [2:0] cmd_colour = '0;
  logic [7:0] cmd_cx = '0;
  logic [6:0] cmd_cy = '0;
  logic [7:0] cmd_r = '0;
  logic       fill_rst_n, fill_start;
  logic [2:0] fill_colour;
  logic       fill_done;
  logic [7:0] fill_x;
  logic [6:0] fill_y;
  logic       fill_plot;
  logic [2:0] fill_vcolour;
  logic       circ_rst_n, circ_start;
  logic [2:0] circ_colour;
  logic [7:0] circ_cx;
  logic [6:0] circ_cy;
  logic [7:0] circ_r;
  logic       circ_done;
  logic [7:0] circ_x;
  logic [6:0] circ_y;
  logic       circ_plot;
  logic [2:0] circ_vcolour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       idle, err;
  logic [7:0] done_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  draw_sequencer #(.DEPTH(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_colour(cmd_colour), .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_r(cmd_r),
    .fill_rst_n(fill_rst_n), .fill_start(fill_start), .fill_colour(fill_colour),
    .fill_done(fill_done), .fill_x(fill_x), .fill_y(fill_y),
    .fill_plot(fill_plot), .fill_vcolour(fill_vcolour),
    .circ_rst_n(circ_rst_n), .circ_start(circ_start), .circ_colour(circ_colour),
    .circ_cx(circ_cx), .circ_cy(circ_cy), .circ_r(circ_r),
    .circ_done(circ_done), .circ_x(circ_x), .circ_y(circ_y),
    .circ_plot(circ_plot), .circ_vcolour(circ_vcolour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .idle(idle), .err(err), .done_count(done_count)
  );

  // Manual drive of engine outputs, used by the pixel-mux table.
  logic       manual = 1'b0;
  logic [7:0] m_fx = '0, m_cx = '0;
  logic [6:0] m_fy = '0, m_cy = '0;
  logic [2:0] m_fc = '0, m_cc = '0;
  logic       m_fp = 1'b0, m_cp = 1'b0, m_fd = 1'b0, m_cd = 1'b0;

  // Engine models: capture params while held in reset, plot len cycles, then done.
  logic [15:0] c_len = 16'd8, f_len = 16'd8;
  logic        c_hang = 1'b0;
  logic [15:0] c_cnt, f_cnt;
  logic [7:0]  c_cx_cap, c_r_cap;
  logic [6:0]  c_cy_cap;
  logic [2:0]  c_col_cap, f_col_cap;

  always @(posedge clk) begin
    if (!circ_rst_n) begin
      c_cnt     <= '0;
      c_cx_cap  <= circ_cx;
      c_cy_cap  <= circ_cy;
      c_r_cap   <= circ_r;
      c_col_cap <= circ_colour;
    end else if (circ_start && c_cnt < c_len) c_cnt <= c_cnt + 1'b1;
    if (!fill_rst_n) begin
      f_cnt     <= '0;
      f_col_cap <= fill_colour;
    end else if (fill_start && f_cnt < f_len) f_cnt <= f_cnt + 1'b1;
  end

  assign circ_x       = manual ? m_cx : c_cx_cap + c_cnt[7:0];
  assign circ_y       = manual ? m_cy : c_cy_cap;
  assign circ_vcolour = manual ? m_cc : c_col_cap;
  assign circ_plot    = manual ? m_cp : (circ_rst_n && circ_start && c_cnt < c_len);
  assign circ_done    = manual ? m_cd : (circ_rst_n && c_cnt == c_len && !c_hang);
  assign fill_x       = manual ? m_fx : f_cnt[7:0];
  assign fill_y       = manual ? m_fy : 7'd1;
  assign fill_vcolour = manual ? m_fc : f_col_cap;
  assign fill_plot    = manual ? m_fp : (fill_rst_n && fill_start && f_cnt < f_len);
  assign fill_done    = manual ? m_fd : (fill_rst_n && f_cnt == f_len);

  // Monitor: start-rise events (execution order), plot and run-cycle counters.
  typedef struct {
    logic       op;
    logic [2:0] col;
    int         at;
  } ev_t;
  ev_t evq[$];
  logic prev_cs = 1'b0, prev_fs = 1'b0;
  int plot_cnt = 0, circ_run_cnt = 0, pix_bad = 0;

  always @(negedge clk) begin
    ev_t e;
    if (circ_start && !prev_cs) begin
      e.op = 1'b1; e.col = circ_colour; e.at = cyc; evq.push_back(e);
    end
    if (fill_start && !prev_fs) begin
      e.op = 1'b0; e.col = fill_colour; e.at = cyc; evq.push_back(e);
    end
    prev_cs = circ_start;
    prev_fs = fill_start;
    if (vga_plot) plot_cnt++;
    if (circ_start) circ_run_cnt++;
    if (circ_start && {vga_x, vga_y, vga_colour, vga_plot} !== {circ_x, circ_y, circ_vcolour, circ_plot}) pix_bad++;
    if (fill_start && {vga_x, vga_y, vga_colour, vga_plot} !== {fill_x, fill_y, fill_vcolour, fill_plot}) pix_bad++;
  end

  typedef struct {
    logic       op;
    logic [7:0] fx; logic [6:0] fy; logic [2:0] fc; logic fp;
    logic [7:0] cx; logic [6:0] cy; logic [2:0] cc; logic cp;
    logic [7:0] ex; logic [6:0] ey; logic [2:0] ec; logic ep;
  } vec_t;
  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    m_fx = v.fx; m_fy = v.fy; m_fc = v.fc; m_fp = v.fp;
    m_cx = v.cx; m_cy = v.cy; m_cc = v.cc; m_cp = v.cp;
    @(negedge clk);
  endtask

  task automatic pushCmd(input logic op, input logic [2:0] col, input logic [7:0] cx,
                         input logic [6:0] cy, input logic [7:0] r,
                         output int waits, output int acc);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_colour = col; cmd_cx = cx; cmd_cy = cy; cmd_r = r;
    waits = 0;
    while (!cmd_ready && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) checkOutput("push_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic waitIdle(input int limit);
    int t = 0;
    @(negedge clk);
    while (!idle && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (!idle) checkOutput("idle_wait", 32'(idle), 32'd1);
  endtask

  task automatic waitStart(input logic op);
    int t = 0;
    @(negedge clk);
    while (!(op ? circ_start : fill_start) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!(op ? circ_start : fill_start)) checkOutput("start_wait", 32'd0, 32'd1);
  endtask

  int w, a, w2, a2, base, k, g, gap_plot, p0, b0, r0, t;
  int acc6;
  int cur;
  logic [25:0] load_snap;
  logic load_rst;
  logic [3:0] exp_ord [6];

  initial begin
    // Pixel-mux vectors: circle running, then fill running; idle engine ignored.
    vecs[0] = '{1'b1, 8'd5,   7'd6,   3'd7, 1'b1, 8'd10,  7'd20,  3'd3, 1'b1, 8'd10,  7'd20,  3'd3, 1'b1};
    vecs[1] = '{1'b1, 8'd5,   7'd6,   3'd7, 1'b1, 8'd0,   7'd0,   3'd0, 1'b0, 8'd0,   7'd0,   3'd0, 1'b0};
    vecs[2] = '{1'b1, 8'd0,   7'd0,   3'd0, 1'b0, 8'd159, 7'd119, 3'd7, 1'b1, 8'd159, 7'd119, 3'd7, 1'b1};
    vecs[3] = '{1'b1, 8'd1,   7'd1,   3'd1, 1'b1, 8'd33,  7'd44,  3'd5, 1'b0, 8'd33,  7'd44,  3'd5, 1'b0};
    vecs[4] = '{1'b0, 8'd12,  7'd34,  3'd2, 1'b1, 8'd99,  7'd98,  3'd6, 1'b1, 8'd12,  7'd34,  3'd2, 1'b1};
    vecs[5] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 8'd7,   7'd7,   3'd7, 1'b1, 8'd0,   7'd0,   3'd0, 1'b0};
    vecs[6] = '{1'b0, 8'd159, 7'd119, 3'd4, 1'b1, 8'd1,   7'd2,   3'd3, 1'b1, 8'd159, 7'd119, 3'd4, 1'b1};
    vecs[7] = '{1'b0, 8'd80,  7'd60,  3'd1, 1'b0, 8'd1,   7'd2,   3'd3, 1'b1, 8'd80,  7'd60,  3'd1, 1'b0};

    #12;
    checkOutput("rst_idle", 32'(idle), 32'd1);
    checkOutput("rst_vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'd0);
    checkOutput("rst_eng", 32'({fill_rst_n, fill_start, circ_rst_n, circ_start}), 32'd0);
    checkOutput("rst_cnt_err", 32'({done_count, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);

    // Table-driven pixel-mux vectors in manual mode.
    $display("[TB] pixel mux table");
    manual = 1'b1;
    cur = 2;
    for (int i = 0; i < 8; i++) begin
      if (int'(vecs[i].op) != cur) begin
        if (cur != 2) begin
          @(posedge clk); #1;
          if (cur == 1) m_cd = 1'b1; else m_fd = 1'b1;
          waitIdle(50);
          m_cd = 1'b0; m_fd = 1'b0;
        end
        pushCmd(vecs[i].op, 3'd1, 8'd2, 7'd3, 8'd4, w, a);
        cmd_valid = 1'b0;
        waitStart(vecs[i].op);
        cur = int'(vecs[i].op);
      end
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), 32'({vga_x, vga_y, vga_colour, vga_plot}),
                  32'({vecs[i].ex, vecs[i].ey, vecs[i].ec, vecs[i].ep}));
    end
    @(posedge clk); #1;
    m_fd = 1'b1;
    waitIdle(50);
    m_fd = 1'b0;
    manual = 1'b0;
    checkOutput("table_done_count", 32'(done_count), 32'd2);

    // Single circle: start latency, params stable in LOAD, every plot forwarded.
    $display("[TB] single circle");
    c_len = 16'd12;
    p0 = plot_cnt; b0 = pix_bad;
    pushCmd(1'b1, 3'b010, 8'd80, 7'd60, 8'd40, w, a);
    cmd_valid = 1'b0;
    k = 0; load_snap = '0; load_rst = 1'b1;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (circ_start) break;
      load_snap = {circ_colour, circ_cx, circ_cy, circ_r};
      load_rst = circ_rst_n;
    end
    checkOutput("start_latency_negedges", 32'(k), 32'd3);
    checkOutput("load_params", 32'(load_snap), 32'({3'b010, 8'd80, 7'd60, 8'd40}));
    checkOutput("load_rst_low", 32'(load_rst), 32'd0);
    waitIdle(100);
    checkOutput("engine_captured", 32'({c_col_cap, c_cx_cap, c_cy_cap, c_r_cap}), 32'({3'b010, 8'd80, 7'd60, 8'd40}));
    checkOutput("plot_count", 32'(plot_cnt - p0), 32'd12);
    checkOutput("pix_forward_bad", 32'(pix_bad - b0), 32'd0);
    checkOutput("c1_done_count", 32'(done_count), 32'd3);
    checkOutput("c1_idle", 32'(idle), 32'd1);

    // Back-to-back fill then circle with cmd_valid held.
    $display("[TB] back to back");
    f_len = 16'd6; c_len = 16'd10;
    base = evq.size();
    pushCmd(1'b0, 3'd0, 8'd0, 7'd0, 8'd0, w, a);
    pushCmd(1'b1, 3'd5, 8'd20, 7'd30, 8'd10, w2, a2);
    cmd_valid = 1'b0;
    checkOutput("b2b_accept_next", 32'(a2 - a), 32'd1);
    waitStart(1'b0);
    t = 0;
    while (fill_start && t < 500) begin @(negedge clk); t++; end
    g = 0; gap_plot = 0;
    while (!circ_start && g < 50) begin
      g++;
      if (vga_plot) gap_plot++;
      @(negedge clk);
    end
    checkOutput("gap_cycles_incl_load", 32'(g), 32'd3);
    checkOutput("gap_plot", 32'(gap_plot), 32'd0);
    waitIdle(100);
    checkOutput("b2b_events", 32'(evq.size() - base), 32'd2);
    if (evq.size() - base >= 2)
      checkOutput("b2b_order", 32'({evq[base].op, evq[base+1].op}), 32'({1'b0, 1'b1}));
    checkOutput("b2b_done_count", 32'(done_count), 32'd5);

    // FIFO fill while the first command runs; order preserved.
    $display("[TB] fifo depth");
    c_len = 16'd20; f_len = 16'd5;
    base = evq.size();
    pushCmd(1'b1, 3'd1, 8'd1, 7'd1, 8'd1, w, a);
    cmd_valid = 1'b0;
    waitStart(1'b1);
    pushCmd(1'b0, 3'd2, 8'd0, 7'd0, 8'd0, w, a);
    pushCmd(1'b1, 3'd3, 8'd3, 7'd3, 8'd3, w, a);
    pushCmd(1'b0, 3'd4, 8'd0, 7'd0, 8'd0, w, a);
    pushCmd(1'b1, 3'd5, 8'd5, 7'd5, 8'd5, w, a);
    @(negedge clk);
    checkOutput("full_ready_low", 32'(cmd_ready), 32'd0);
    pushCmd(1'b0, 3'd6, 8'd0, 7'd0, 8'd0, w, acc6);
    cmd_valid = 1'b0;
    waitIdle(400);
    exp_ord[0] = {1'b1, 3'd1}; exp_ord[1] = {1'b0, 3'd2}; exp_ord[2] = {1'b1, 3'd3};
    exp_ord[3] = {1'b0, 3'd4}; exp_ord[4] = {1'b1, 3'd5}; exp_ord[5] = {1'b0, 3'd6};
    checkOutput("fifo_events", 32'(evq.size() - base), 32'd6);
    if (evq.size() - base >= 6) begin
      for (int i = 0; i < 6; i++)
        checkOutput($sformatf("order%0d", i), 32'({evq[base+i].op, evq[base+i].col}), 32'(exp_ord[i]));
      checkOutput("sixth_accept_after_pop", 32'(acc6), 32'(evq[base+1].at));
    end
    checkOutput("fifo_done_count", 32'(done_count), 32'd11);
    checkOutput("no_err_yet", 32'(err), 32'd0);

    // Timeout: circle never completes, queued fill still runs.
    $display("[TB] timeout");
    c_hang = 1'b1; c_len = 16'd5; f_len = 16'd4;
    r0 = circ_run_cnt;
    base = evq.size();
    pushCmd(1'b1, 3'd7, 8'd9, 7'd9, 8'd9, w, a);
    pushCmd(1'b0, 3'd3, 8'd0, 7'd0, 8'd0, w, a);
    cmd_valid = 1'b0;
    waitIdle(400);
    c_hang = 1'b0;
    checkOutput("timeout_run_cycles", 32'(circ_run_cnt - r0), 32'd100);
    checkOutput("err_sticky", 32'(err), 32'd1);
    checkOutput("timeout_done_count", 32'(done_count), 32'd12);
    checkOutput("timeout_events", 32'(evq.size() - base), 32'd2);

    // Asynchronous reset in the middle of RUN with commands queued.
    $display("[TB] reset mid run");
    c_len = 16'd30;
    pushCmd(1'b1, 3'd2, 8'd4, 7'd4, 8'd4, w, a);
    pushCmd(1'b0, 3'd1, 8'd0, 7'd0, 8'd0, w, a);
    pushCmd(1'b1, 3'd6, 8'd6, 7'd6, 8'd6, w, a);
    cmd_valid = 1'b0;
    waitStart(1'b1);
    checkOutput("pre_reset_plot", 32'(vga_plot), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'd0);
    checkOutput("mid_rst_eng", 32'({fill_rst_n, fill_start, circ_rst_n, circ_start}), 32'd0);
    checkOutput("mid_rst_idle", 32'(idle), 32'd1);
    checkOutput("mid_rst_cnt_err", 32'({done_count, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = evq.size();
    repeat (40) @(negedge clk);
    checkOutput("post_rst_no_exec", 32'(evq.size() - base), 32'd0);
    checkOutput("post_rst_idle_ready", 32'({idle, cmd_ready}), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
